// File: rtl/snap_vacc_capture_ctrl_if.sv
// Control, sample and BRAM-write bundle for snap_vacc_capture_ctrl.
// Adds the tstamp output when SNAP_TSTAMP_EN is defined.
interface snap_vacc_capture_ctrl_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 64
);
  logic [31:0]       ctrl;
  logic [DATA_W-1:0] din;
  logic              din_we;
  logic              trig;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_data;
  logic              bram_we;
  logic [31:0]       status;
  logic              done;
`ifdef SNAP_TSTAMP_EN
  logic [31:0]       tstamp;

  modport master (
    output ctrl, din, din_we, trig,
    input  bram_addr, bram_data, bram_we, status, done, tstamp
  );
  modport slave (
    input  ctrl, din, din_we, trig,
    output bram_addr, bram_data, bram_we, status, done, tstamp
  );
`else
  modport master (
    output ctrl, din, din_we, trig,
    input  bram_addr, bram_data, bram_we, status, done
  );
  modport slave (
    input  ctrl, din, din_we, trig,
    output bram_addr, bram_data, bram_we, status, done
  );
`endif
endinterface

// File: rtl/snap_vacc_capture_ctrl.sv
// One-shot snapshot sequencer: captures 2^ADDR_W vacc samples into BRAM and reports status.
// Optional arm-to-trigger timestamp output enabled by SNAP_TSTAMP_EN.
module snap_vacc_capture_ctrl #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 64
) (
  input logic                    user_clk,
  input logic                    user_rst_n,
  snap_vacc_capture_ctrl_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StArmed, StCapture, StDone} state_e;

  state_e              state_q;
  logic                en_q;
  logic                done_q;
  logic                we_q;
  logic [ADDR_W:0]     count_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;

  logic en, qwe, start, en_rise, do_write, last_write, busy;
  logic [31:0] status;
  logic unused_ctrl;

  always_comb begin
    en         = bus.ctrl[0];
    qwe        = bus.ctrl[2] ? bus.din_we : 1'b1;
    start      = bus.ctrl[1] ? bus.trig : 1'b1;
    en_rise    = en & ~en_q;
    // The ARMED write lands at count 0 because arming clears count.
    do_write   = en & qwe & (((state_q == StArmed) & start) | (state_q == StCapture));
    last_write = &count_q[ADDR_W-1:0];
    busy       = (state_q == StArmed) | (state_q == StCapture);
  end

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      state_q <= StIdle;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      count_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      en_q <= en;
      we_q <= 1'b0;
      if (do_write) begin
        we_q    <= 1'b1;
        addr_q  <= count_q[ADDR_W-1:0];
        data_q  <= bus.din;
        count_q <= count_q + (ADDR_W+1)'(1);
      end
      unique case (state_q)
        StIdle: begin
          if (en_rise) begin
            state_q <= StArmed;
            count_q <= '0;
            done_q  <= 1'b0;
          end
        end
        StArmed: begin
          if (!en) begin
            state_q <= StIdle;
          end else if (start) begin
            state_q <= (do_write && last_write) ? StDone : StCapture;
            if (do_write && last_write) done_q <= 1'b1;
          end
        end
        StCapture: begin
          if (!en) begin
            state_q <= StIdle;
          end else if (do_write && last_write) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end
        end
        StDone: begin
          if (!en) state_q <= StIdle;
        end
      endcase
    end
  end

  always_comb begin
    status             = '0;
    status[31]         = done_q;
    status[30]         = busy;
    status[ADDR_W:0]   = count_q;
  end

  assign unused_ctrl   = ^bus.ctrl[31:3];
  assign bus.status    = status;
  assign bus.done      = done_q;
  assign bus.bram_we   = we_q;
  assign bus.bram_addr = addr_q;
  assign bus.bram_data = data_q;

`ifdef SNAP_TSTAMP_EN
  logic [31:0] ts_cnt_q;
  logic [31:0] tstamp_q;

  // Latch the post-edge counter value so the result counts cycles from en_rise to trigger.
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      ts_cnt_q <= '0;
      tstamp_q <= '0;
    end else begin
      ts_cnt_q <= en_rise ? '0 : ts_cnt_q + 32'd1;
      if ((state_q == StArmed) && en && start) tstamp_q <= ts_cnt_q + 32'd1;
    end
  end

  assign bus.tstamp = tstamp_q;
`endif

endmodule

// File: tb/tb_snap_vacc_capture_ctrl.sv
// Self-checking bench for snap_vacc_capture_ctrl: vector table, directed captures and
// randomized captures scored against a sequence-level model of the capture rules.
module tb_snap_vacc_capture_ctrl;
  localparam int unsigned AW    = 4;
  localparam int unsigned DW    = 64;
  localparam int          NSAMP = 16;
  localparam int          MAXC  = 160;

  logic user_clk   = 1'b0;
  logic user_rst_n = 1'b0;

  snap_vacc_capture_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  snap_vacc_capture_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .user_clk   (user_clk),
    .user_rst_n (user_rst_n),
    .bus        (bus)
  );

  always #5 user_clk = ~user_clk;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] last_data;

  logic [31:0]   sc_ctrl [MAXC];
  logic [DW-1:0] sc_din  [MAXC];
  logic          sc_we   [MAXC];
  logic          sc_trig [MAXC];
  int            sc_n;

  typedef struct {
    logic [31:0]   ctrl;
    logic [DW-1:0] din;
    logic          din_we;
    logic          trig;
    logic          exp_we;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;
    logic [31:0]   exp_status;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply(input logic [31:0] c, input logic [DW-1:0] d, input logic w,
                       input logic tr);
    bus.ctrl   = c;
    bus.din    = d;
    bus.din_we = w;
    bus.trig   = tr;
    @(posedge user_clk);
    #1;
  endtask

  task automatic do_reset();
    user_rst_n = 1'b0;
    bus.ctrl = '0; bus.din = '0; bus.din_we = 1'b0; bus.trig = 1'b0;
    repeat (2) @(posedge user_clk);
    #1;
    user_rst_n = 1'b1;
    last_data  = '0;
    chk("rst_status", 64'(bus.status), 64'h0);
    chk("rst_done", 64'(bus.done), 64'h0);
    chk("rst_we", 64'(bus.bram_we), 64'h0);
    chk("rst_addr", 64'(bus.bram_addr), 64'h0);
    chk("rst_data", bus.bram_data, 64'h0);
`ifdef SNAP_TSTAMP_EN
    chk("rst_tstamp", 64'(bus.tstamp), 64'h0);
`endif
  endtask

  // Model: from the recorded stimulus, find the arm cycle, the trigger cycle and the ordered
  // list of qualified samples; every output cycle is then derived from that list.
  task automatic run_scenario(input string tag, input int init_cnt, input bit init_done,
                              output int fin_cnt, output bit fin_done);
    int a = -1, s = -1, stop = -1, nw = 0;
    int wcyc [NSAMP];
    logic [DW-1:0] wdat [NSAMP];
    for (int t = 1; t < sc_n && a < 0; t++)
      if (sc_ctrl[t][0] && !sc_ctrl[t-1][0]) a = t;
    if (a >= 0) begin
      for (int t = a + 1; t < sc_n && stop < 0; t++) begin
        if (!sc_ctrl[t][0]) begin
          stop = t;
        end else begin
          if (s < 0 && (sc_ctrl[t][1] ? sc_trig[t] : 1'b1)) s = t;
          if (s >= 0 && (sc_ctrl[t][2] ? sc_we[t] : 1'b1)) begin
            wcyc[nw] = t;
            wdat[nw] = sc_din[t];
            nw++;
            if (nw == NSAMP) stop = t;
          end
        end
      end
      if (stop < 0) stop = sc_n;
    end
    fin_cnt  = init_cnt;
    fin_done = init_done;
    for (int t = 0; t < sc_n; t++) begin
      int cnt = init_cnt;
      bit dn = init_done;
      bit busy = 1'b0;
      bit we = 1'b0;
      int k = 0;
      logic [31:0] es = '0;
      apply(sc_ctrl[t], sc_din[t], sc_we[t], sc_trig[t]);
      if (a >= 0 && t >= a) begin
        cnt = 0;
        for (int i = 0; i < nw; i++) if (wcyc[i] <= t) cnt++;
        dn   = (nw == NSAMP) && (t >= stop);
        busy = (t < stop);
      end
      for (int i = 0; i < nw; i++) if (wcyc[i] == t) begin we = 1'b1; k = i; end
      es[31]   = dn;
      es[30]   = busy;
      es[AW:0] = cnt[AW:0];
      chk($sformatf("%s.status@%0d", tag, t), 64'(bus.status), 64'(es));
      chk($sformatf("%s.done@%0d", tag, t), 64'(bus.done), 64'(dn));
      chk($sformatf("%s.we@%0d", tag, t), 64'(bus.bram_we), 64'(we));
      if (we) begin
        chk($sformatf("%s.addr@%0d", tag, t), 64'(bus.bram_addr), 64'(k));
        last_data = wdat[k];
      end
      chk($sformatf("%s.data@%0d", tag, t), bus.bram_data, last_data);
      fin_cnt  = cnt;
      fin_done = dn;
    end
  endtask

  // Enable high over [2, en_end), low elsewhere; mode sets ctrl[2:1].
  task automatic fill(input int n, input int en_end, input logic [1:0] mode,
                      input logic [28:0] junk);
    sc_n = n;
    for (int t = 0; t < n; t++) begin
      sc_ctrl[t] = {junk, mode, (t >= 2 && t < en_end)};
      sc_din[t]  = {$urandom, $urandom};
      sc_we[t]   = 1'b0;
      sc_trig[t] = 1'b0;
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int fc;
    bit fd;
    tbl[0]  = '{32'h0,         64'h11, 1'b0, 1'b0, 1'b0, 4'd0, 64'h0,  32'h0};
    tbl[1]  = '{32'h7,         64'h22, 1'b1, 1'b0, 1'b0, 4'd0, 64'h0,  32'h40000000};
    tbl[2]  = '{32'h7,         64'h33, 1'b1, 1'b0, 1'b0, 4'd0, 64'h0,  32'h40000000};
    tbl[3]  = '{32'h7,         64'h44, 1'b0, 1'b1, 1'b0, 4'd0, 64'h0,  32'h40000000};
    tbl[4]  = '{32'h7,         64'h55, 1'b0, 1'b0, 1'b0, 4'd0, 64'h0,  32'h40000000};
    tbl[5]  = '{32'h7,         64'h66, 1'b1, 1'b1, 1'b1, 4'd0, 64'h66, 32'h40000001};
    tbl[6]  = '{32'h7,         64'h77, 1'b1, 1'b0, 1'b1, 4'd1, 64'h77, 32'h40000002};
    tbl[7]  = '{32'h7,         64'h88, 1'b0, 1'b0, 1'b0, 4'd0, 64'h77, 32'h40000002};
    tbl[8]  = '{32'h6,         64'h99, 1'b1, 1'b1, 1'b0, 4'd0, 64'h77, 32'h00000002};
    tbl[9]  = '{32'hDEADBEE6,  64'hAA, 1'b1, 1'b0, 1'b0, 4'd0, 64'h77, 32'h00000002};
    tbl[10] = '{32'h12345677,  64'hBB, 1'b1, 1'b0, 1'b0, 4'd0, 64'h77, 32'h40000000};
    tbl[11] = '{32'h7,         64'hCC, 1'b1, 1'b1, 1'b1, 4'd0, 64'hCC, 32'h40000001};
    tbl[12] = '{32'h6,         64'hDD, 1'b1, 1'b1, 1'b0, 4'd0, 64'hCC, 32'h00000001};

    do_reset();
    for (int i = 0; i < 13; i++) begin
      apply(tbl[i].ctrl, tbl[i].din, tbl[i].din_we, tbl[i].trig);
      chk($sformatf("tbl%0d.status", i), 64'(bus.status), 64'(tbl[i].exp_status));
      chk($sformatf("tbl%0d.done", i), 64'(bus.done), 64'(tbl[i].exp_status[31]));
      chk($sformatf("tbl%0d.we", i), 64'(bus.bram_we), 64'(tbl[i].exp_we));
      if (tbl[i].exp_we) chk($sformatf("tbl%0d.addr", i), 64'(bus.bram_addr), 64'(tbl[i].exp_addr));
      chk($sformatf("tbl%0d.data", i), bus.bram_data, tbl[i].exp_data);
    end

    // Immediate, every-cycle capture of a ramp.
    do_reset();
    fill(30, 25, 2'b00, '0);
    for (int t = 3; t < 30; t++) sc_din[t] = 64'h100 + 64'(t - 3);
    run_scenario("ramp", 0, 1'b0, fc, fd);
    chk("ramp.final_status", 64'(bus.status), 64'h80000010);
    chk("ramp.final_done", 64'(bus.done), 64'h1);

    // External trigger 7 cycles after arm.
    do_reset();
    fill(40, 35, 2'b01, '0);
    sc_trig[9] = 1'b1;
    run_scenario("trig7", 0, 1'b0, fc, fd);

    // Qualified by din_we every third cycle.
    do_reset();
    fill(70, 65, 2'b10, '0);
    for (int t = 0; t < 70; t++) sc_we[t] = (t % 3 == 0);
    run_scenario("we3", 0, 1'b0, fc, fd);

    // Abort after 5 writes, then re-arm restarts at address 0.
    do_reset();
    fill(12, 8, 2'b00, '0);
    run_scenario("abort", 0, 1'b0, fc, fd);
    chk("abort.final_status", 64'(bus.status), 64'h5);
    fill(10, 6, 2'b00, '0);
    run_scenario("rearm", fc, fd, fc, fd);

    // Enable held well past DONE, then a fresh edge starts a new capture.
    do_reset();
    fill(80, 76, 2'b00, '0);
    run_scenario("hold", 0, 1'b0, fc, fd);
    fill(30, 25, 2'b00, '0);
    run_scenario("hold2", fc, fd, fc, fd);

    // Asynchronous reset mid-capture.
    do_reset();
    apply(32'h0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) apply(32'h1, {$urandom, $urandom}, 1'b0, 1'b0);
    #3;
    user_rst_n = 1'b0;
    #1;
    chk("arst.status", 64'(bus.status), 64'h0);
    chk("arst.done", 64'(bus.done), 64'h0);
    chk("arst.we", 64'(bus.bram_we), 64'h0);
    chk("arst.addr", 64'(bus.bram_addr), 64'h0);
    chk("arst.data", bus.bram_data, 64'h0);
    bus.ctrl = '0;
    @(posedge user_clk);
    #1;
    user_rst_n = 1'b1;
    last_data  = '0;
    fill(30, 25, 2'b00, '0);
    run_scenario("post_rst", 0, 1'b0, fc, fd);

    // Randomized captures chained without reset.
    for (int r = 0; r < 30; r++) begin
      int en_end = ($urandom_range(0, 3) == 0) ? $urandom_range(3, 30) : $urandom_range(70, 86);
      int wp = $urandom_range(1, 3);
      fill(90, en_end, 2'($urandom_range(0, 3)), 29'($urandom));
      for (int t = 0; t < 90; t++) begin
        sc_we[t]   = ($urandom_range(1, wp) == 1);
        sc_trig[t] = ($urandom_range(0, 9) == 0);
      end
      run_scenario($sformatf("rnd%0d", r), fc, fd, fc, fd);
    end

`ifdef SNAP_TSTAMP_EN
    do_reset();
    fill(140, 130, 2'b01, '0);
    sc_trig[102] = 1'b1;
    run_scenario("tstamp", 0, 1'b0, fc, fd);
    chk("tstamp.value", 64'(bus.tstamp), 64'd100);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
